// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared frame geometry, unpack phase and sync state encodings
package video_pkg;

    localparam int X_SIZE_DEF = 640;
    localparam int Y_SIZE_DEF = 480;

    typedef enum logic [1:0] {
        P0 = 2'd0,
        P1 = 2'd1,
        P2 = 2'd2,
        P3 = 2'd3
    } phase_t;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } sync_t;

    // First byte of a pixel in the stream is red, then green, then blue.
    function automatic logic [23:0] rgb_pack(input logic [7:0] i_b0,
                                             input logic [7:0] i_b1,
                                             input logic [7:0] i_b2);
        return {i_b0, i_b1, i_b2};
    endfunction

endpackage

// File: rtl/pixel_coord_counter.sv
// rtl/pixel_coord_counter.sv - x/y position, sof/eol flags and frame count of the presented pixel
module pixel_coord_counter
    import video_pkg::*;
#(
    parameter int X_SIZE = X_SIZE_DEF,
    parameter int Y_SIZE = Y_SIZE_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic       i_restart,
    input  logic       i_accept,
    output logic [9:0] o_x,
    output logic [8:0] o_y,
    output logic       o_sof,
    output logic       o_eol,
    output logic       o_next_origin,
    output logic [7:0] o_frame_count
);

    localparam logic [9:0] LAST_X = 10'(X_SIZE - 1);
    localparam logic [8:0] LAST_Y = 9'(Y_SIZE - 1);

    logic [9:0] r_nx;
    logic [8:0] r_ny;
    logic [9:0] r_x;
    logic [8:0] r_y;
    logic       r_sof;
    logic       r_eol;
    logic [7:0] r_frame_count;

    logic [9:0] w_lx;
    logic [8:0] w_ly;
    logic       w_last_pix;

    // Coordinate given to the pixel being loaded; a restart forces the frame origin.
    assign w_lx       = i_restart ? 10'd0 : r_nx;
    assign w_ly       = i_restart ? 9'd0  : r_ny;
    assign w_last_pix = (r_x == LAST_X) && (r_y == LAST_Y);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_nx          <= '0;
            r_ny          <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_sof         <= 1'b0;
            r_eol         <= 1'b0;
            r_frame_count <= '0;
        end else begin
            if (i_load) begin
                r_x   <= w_lx;
                r_y   <= w_ly;
                r_sof <= (w_lx == 10'd0) && (w_ly == 9'd0);
                r_eol <= (w_lx == LAST_X);
                if (w_lx == LAST_X) begin
                    r_nx <= '0;
                    r_ny <= (w_ly == LAST_Y) ? 9'd0 : w_ly + 9'd1;
                end else begin
                    r_nx <= w_lx + 10'd1;
                    r_ny <= w_ly;
                end
            end
            if (i_accept && w_last_pix) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
        end
    end

    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_sof         = r_sof;
    assign o_eol         = r_eol;
    assign o_next_origin = (r_nx == 10'd0) && (r_ny == 9'd0);
    assign o_frame_count = r_frame_count;

endmodule

// File: rtl/stream_unpacker.sv
// rtl/stream_unpacker.sv - unpacks 3 words of packed RGB bytes into 4 pixels with frame sync checks
module stream_unpacker
    import video_pkg::*;
#(
    parameter int X_SIZE = X_SIZE_DEF,
    parameter int Y_SIZE = Y_SIZE_DEF
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] in_stream_tdata,
    input  logic [3:0]  in_stream_tkeep,
    input  logic        in_stream_tlast,
    input  logic        in_stream_tuser,
    input  logic        in_stream_tvalid,
    output logic        in_stream_tready,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        pix_sof,
    output logic        pix_eol,
    input  logic        err_clr,
    output logic        err_sof,
    output logic        err_eol,
    output logic [7:0]  frame_count
);

    localparam int         WPL       = 3 * X_SIZE / 4;
    localparam logic [9:0] LAST_WORD = 10'(WPL - 1);

    sync_t       r_state;
    sync_t       w_state_nxt;
    phase_t      r_phase;
    phase_t      w_phase_nxt;
    logic        r_active;
    logic [31:0] r_word;
    logic [23:0] r_pix_data;
    logic [23:0] w_pix_nxt;
    logic        r_pix_valid;
    logic [9:0]  r_wcnt;
    logic [9:0]  w_widx;
    logic        r_err_sof;
    logic        r_err_eol;

    logic        w_adv;
    logic        w_acc;
    logic        w_load;
    logic        w_restart;
    logic        w_first;
    logic        w_origin;
    logic        w_counted;
    logic        w_sof_err;
    logic        w_eol_err;
    logic        w_unused;

    assign w_unused = ^in_stream_tkeep;

    // r_active holds tready low through reset and for the first edge after release.
    assign w_adv            = !r_pix_valid || pix_ready;
    assign in_stream_tready = r_active && ((r_state == HUNT) || ((r_phase != P3) && w_adv));
    assign w_acc            = in_stream_tvalid && in_stream_tready;
    assign w_first          = (r_phase == P0) && w_origin;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= HUNT;
            r_phase <= P0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_load      = 1'b0;
        w_restart   = 1'b0;
        w_pix_nxt   = rgb_pack(in_stream_tdata[7:0], in_stream_tdata[15:8], in_stream_tdata[23:16]);
        case (r_state)
            HUNT: begin
                if (w_acc && in_stream_tuser) begin
                    w_restart   = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                    w_phase_nxt = P1;
                end
            end
            RUN: begin
                if (w_acc && in_stream_tuser) begin
                    w_restart   = 1'b1;
                    w_load      = 1'b1;
                    w_phase_nxt = P1;
                end else if (w_acc || ((r_phase == P3) && w_adv)) begin
                    w_load = 1'b1;
                    case (r_phase)
                        P0: begin
                            w_phase_nxt = P1;
                        end
                        P1: begin
                            w_phase_nxt = P2;
                            w_pix_nxt   = rgb_pack(r_word[31:24], in_stream_tdata[7:0],
                                                   in_stream_tdata[15:8]);
                        end
                        P2: begin
                            w_phase_nxt = P3;
                            w_pix_nxt   = rgb_pack(r_word[23:16], r_word[31:24],
                                                   in_stream_tdata[7:0]);
                        end
                        default: begin
                            w_phase_nxt = P0;
                            w_pix_nxt   = rgb_pack(r_word[15:8], r_word[23:16], r_word[31:24]);
                        end
                    endcase
                end
            end
            default: begin
                w_state_nxt = HUNT;
                w_phase_nxt = P0;
            end
        endcase
    end

    // Words discarded while hunting take no part in line-length checking.
    assign w_counted = w_acc && ((r_state == RUN) || in_stream_tuser);
    assign w_widx    = w_restart ? 10'd0 : r_wcnt;
    assign w_eol_err = w_counted && (in_stream_tlast != (w_widx == LAST_WORD));
    assign w_sof_err = w_acc && in_stream_tuser && (r_state == RUN) && !w_first;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_active    <= 1'b0;
            r_word      <= '0;
            r_pix_data  <= '0;
            r_pix_valid <= 1'b0;
            r_wcnt      <= '0;
            r_err_sof   <= 1'b0;
            r_err_eol   <= 1'b0;
        end else begin
            r_active <= 1'b1;
            if (w_acc) begin
                r_word <= in_stream_tdata;
            end
            if (w_load) begin
                r_pix_data  <= w_pix_nxt;
                r_pix_valid <= 1'b1;
            end else if (pix_ready) begin
                r_pix_valid <= 1'b0;
            end
            if (w_counted) begin
                r_wcnt <= (w_widx == LAST_WORD) ? 10'd0 : w_widx + 10'd1;
            end
            r_err_sof <= (r_err_sof && !err_clr) || w_sof_err;
            r_err_eol <= (r_err_eol && !err_clr) || w_eol_err;
        end
    end

    pixel_coord_counter #(
        .X_SIZE(X_SIZE),
        .Y_SIZE(Y_SIZE)
    ) u_coord (
        .i_clk         (aclk),
        .i_rst_n       (aresetn),
        .i_load        (w_load),
        .i_restart     (w_restart),
        .i_accept      (r_pix_valid && pix_ready),
        .o_x           (pix_x),
        .o_y           (pix_y),
        .o_sof         (pix_sof),
        .o_eol         (pix_eol),
        .o_next_origin (w_origin),
        .o_frame_count (frame_count)
    );

    assign pix_data  = r_pix_data;
    assign pix_valid = r_pix_valid;
    assign err_sof   = r_err_sof;
    assign err_eol   = r_err_eol;

endmodule

// File: tb/tb_stream_unpacker.sv
// tb/tb_stream_unpacker.sv - self-checking bench for stream_unpacker with a byte-queue reference model
module tb_stream_unpacker;

    localparam int XS  = 16;
    localparam int YS  = 6;
    localparam int WPL = XS * 3 / 4;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] in_stream_tdata;
    logic [3:0]  in_stream_tkeep;
    logic        in_stream_tlast;
    logic        in_stream_tuser;
    logic        in_stream_tvalid;
    logic        in_stream_tready;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        pix_sof;
    logic        pix_eol;
    logic        err_clr;
    logic        err_sof;
    logic        err_eol;
    logic [7:0]  frame_count;

    always #5 aclk = ~aclk;

    stream_unpacker #(
        .X_SIZE(XS),
        .Y_SIZE(YS)
    ) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .in_stream_tdata  (in_stream_tdata),
        .in_stream_tkeep  (in_stream_tkeep),
        .in_stream_tlast  (in_stream_tlast),
        .in_stream_tuser  (in_stream_tuser),
        .in_stream_tvalid (in_stream_tvalid),
        .in_stream_tready (in_stream_tready),
        .pix_data         (pix_data),
        .pix_valid        (pix_valid),
        .pix_ready        (pix_ready),
        .pix_x            (pix_x),
        .pix_y            (pix_y),
        .pix_sof          (pix_sof),
        .pix_eol          (pix_eol),
        .err_clr          (err_clr),
        .err_sof          (err_sof),
        .err_eol          (err_eol),
        .frame_count      (frame_count)
    );

    typedef struct {
        logic        tu;
        logic        tl;
        logic [31:0] d;
    } word_t;

    typedef struct {
        logic [23:0] d;
        logic [9:0]  x;
        logic [8:0]  y;
        logic        sof;
        logic        eol;
    } pix_t;

    typedef struct {
        logic [31:0] d;
        logic        tv;
        logic        tu;
        logic        e_rdy;
        logic        e_vld;
        logic [23:0] e_pix;
        logic [9:0]  e_x;
    } vec_t;

    word_t      q_wd[$];
    pix_t       q_exp[$];
    pix_t       q_got[$];
    logic [7:0] m_buf[$];
    bit         m_hunt;
    int         m_x;
    int         m_y;
    int         m_widx;
    int         exp_fc;
    bit         exp_esof;
    bit         exp_eeol;
    int         checks = 0;
    int         errors = 0;
    vec_t       tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_hunt = 1'b1;
        m_buf.delete();
        m_x      = 0;
        m_y      = 0;
        m_widx   = 0;
        exp_fc   = 0;
        exp_esof = 1'b0;
        exp_eeol = 1'b0;
    endfunction

    // Stream is a flat byte sequence; every three bytes form one pixel in raster order.
    function automatic void model_run();
        foreach (q_wd[i]) begin
            word_t w;
            w = q_wd[i];
            if (!(m_hunt && !w.tu)) begin
                if (w.tu) begin
                    if (!m_hunt && !(m_buf.size() == 0 && m_x == 0 && m_y == 0)) exp_esof = 1'b1;
                    m_hunt = 1'b0;
                    m_buf.delete();
                    m_x    = 0;
                    m_y    = 0;
                    m_widx = 0;
                end
                if (w.tl != (m_widx == WPL - 1)) exp_eeol = 1'b1;
                m_widx = (m_widx + 1) % WPL;
                for (int k = 0; k < 4; k++) m_buf.push_back(w.d[8*k +: 8]);
                while (m_buf.size() >= 3) begin
                    pix_t p;
                    p.d = {m_buf[0], m_buf[1], m_buf[2]};
                    void'(m_buf.pop_front());
                    void'(m_buf.pop_front());
                    void'(m_buf.pop_front());
                    p.x   = 10'(m_x);
                    p.y   = 9'(m_y);
                    p.sof = (m_x == 0 && m_y == 0);
                    p.eol = (m_x == XS - 1);
                    q_exp.push_back(p);
                    if (m_x == XS - 1 && m_y == YS - 1) exp_fc = (exp_fc + 1) % 256;
                    m_x++;
                    if (m_x == XS) begin
                        m_x = 0;
                        m_y = (m_y + 1) % YS;
                    end
                end
            end
        end
    endfunction

    function automatic void push_frame_words(input int nwords, input int bad_line);
        for (int i = 0; i < nwords; i++) begin
            word_t w;
            int    idx;
            int    line;
            idx  = i % WPL;
            line = i / WPL;
            w.d  = $urandom;
            w.tu = (i == 0);
            w.tl = (line == bad_line) ? (idx == WPL - 2) : (idx == WPL - 1);
            q_wd.push_back(w);
        end
    endfunction

    function automatic void push_junk(input int n);
        for (int i = 0; i < n; i++) begin
            word_t w;
            w.d  = $urandom;
            w.tu = 1'b0;
            w.tl = 1'($urandom_range(1));
            q_wd.push_back(w);
        end
    endfunction

    task automatic drive(input int wi, input int vpct, input int rpct);
        in_stream_tkeep = 4'($urandom);
        if (wi < q_wd.size()) begin
            in_stream_tvalid = ($urandom_range(99) < vpct);
            in_stream_tdata  = q_wd[wi].d;
            in_stream_tuser  = q_wd[wi].tu;
            in_stream_tlast  = q_wd[wi].tl;
        end else begin
            in_stream_tvalid = 1'b0;
            in_stream_tdata  = '0;
            in_stream_tuser  = 1'b0;
            in_stream_tlast  = 1'b0;
        end
        pix_ready = ($urandom_range(99) < rpct);
    endtask

    task automatic run_stream(input int vpct, input int rpct);
        int          wi    = 0;
        int          idle  = 0;
        int          cyc   = 0;
        bit          stall = 1'b0;
        logic [23:0] held  = '0;
        q_got.delete();
        @(posedge aclk);
        #1;
        drive(wi, vpct, rpct);
        forever begin
            @(negedge aclk);
            cyc++;
            if (stall) chk("stall_hold", 32'({pix_valid, pix_data}), 32'({1'b1, held}));
            if (pix_valid && pix_ready) begin
                pix_t p;
                p.d   = pix_data;
                p.x   = pix_x;
                p.y   = pix_y;
                p.sof = pix_sof;
                p.eol = pix_eol;
                q_got.push_back(p);
            end
            stall = pix_valid && !pix_ready;
            held  = pix_data;
            if (in_stream_tvalid && in_stream_tready) wi++;
            if (wi >= q_wd.size() && !pix_valid) idle++;
            else idle = 0;
            if (idle >= 4) break;
            if (cyc >= 4000) begin
                checks++;
                errors++;
                $display("FAIL stream_timeout actual=%0d cycles required=<4000 (words %0d of %0d)",
                         cyc, wi, q_wd.size());
                break;
            end
            @(posedge aclk);
            #1;
            drive(wi, vpct, rpct);
        end
        @(posedge aclk);
        #1;
        in_stream_tvalid = 1'b0;
        pix_ready        = 1'b1;
        q_wd.delete();
    endtask

    task automatic compare_out(input string tag);
        chk({tag, "_count"}, 32'(q_got.size()), 32'(q_exp.size()));
        for (int i = 0; i < q_exp.size() && i < q_got.size(); i++) begin
            chk($sformatf("%s_pix%0d_data", tag, i), 32'(q_got[i].d), 32'(q_exp[i].d));
            chk($sformatf("%s_pix%0d_pos", tag, i),
                32'({q_got[i].x, q_got[i].y, q_got[i].sof, q_got[i].eol}),
                32'({q_exp[i].x, q_exp[i].y, q_exp[i].sof, q_exp[i].eol}));
        end
        q_exp.delete();
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_tready"}, 32'(in_stream_tready), 32'd0);
        chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
        chk({tag, "_pix_data"}, 32'(pix_data), 32'd0);
        chk({tag, "_pix_xy"}, 32'({pix_x, pix_y}), 32'd0);
        chk({tag, "_sof_eol"}, 32'({pix_sof, pix_eol}), 32'd0);
        chk({tag, "_errs"}, 32'({err_sof, err_eol}), 32'd0);
        chk({tag, "_frame_count"}, 32'(frame_count), 32'd0);
    endtask

    task automatic apply_reset();
        @(posedge aclk);
        #1;
        aresetn          = 1'b0;
        in_stream_tvalid = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        model_reset();
    endtask

    task automatic check_status(input string tag);
        @(negedge aclk);
        chk({tag, "_frame_count"}, 32'(frame_count), 32'(exp_fc));
        chk({tag, "_err_sof"}, 32'(err_sof), 32'(exp_esof));
        chk({tag, "_err_eol"}, 32'(err_eol), 32'(exp_eeol));
    endtask

    initial begin
        aresetn          = 1'b0;
        in_stream_tdata  = '0;
        in_stream_tkeep  = 4'hF;
        in_stream_tlast  = 1'b0;
        in_stream_tuser  = 1'b0;
        in_stream_tvalid = 1'b0;
        pix_ready        = 1'b0;
        err_clr          = 1'b0;
        model_reset();

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_reset_outs("por");
        aresetn = 1'b1;
        #1;
        chk("tready_before_edge", 32'(in_stream_tready), 32'd0);
        @(posedge aclk);
        #1;
        chk("tready_after_edge", 32'(in_stream_tready), 32'd1);

        tbl[0] = '{32'h6B41CB6B, 1'b1, 1'b1, 1'b1, 1'b0, 24'h000000, 10'd0};
        tbl[1] = '{32'hCB6B41CB, 1'b1, 1'b0, 1'b1, 1'b1, 24'h6BCB41, 10'd0};
        tbl[2] = '{32'h6B41CB41, 1'b1, 1'b0, 1'b1, 1'b1, 24'h6BCB41, 10'd1};
        tbl[3] = '{32'h11223344, 1'b1, 1'b0, 1'b0, 1'b1, 24'h6BCB41, 10'd2};
        tbl[4] = '{32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1, 24'hCB416B, 10'd3};
        pix_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge aclk);
            #1;
            in_stream_tdata  = tbl[i].d;
            in_stream_tvalid = tbl[i].tv;
            in_stream_tuser  = tbl[i].tu;
            in_stream_tlast  = 1'b0;
            @(negedge aclk);
            chk($sformatf("vec%0d_tready", i), 32'(in_stream_tready), 32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d_pix_valid", i), 32'(pix_valid), 32'(tbl[i].e_vld));
            if (tbl[i].e_vld) begin
                chk($sformatf("vec%0d_pix_data", i), 32'(pix_data), 32'(tbl[i].e_pix));
                chk($sformatf("vec%0d_pix_x", i), 32'(pix_x), 32'(tbl[i].e_x));
            end
        end

        apply_reset();
        push_junk(3);
        push_frame_words(WPL * YS, -1);
        push_frame_words(WPL * YS, -1);
        model_run();
        run_stream(70, 50);
        compare_out("rand");
        check_status("rand");

        push_frame_words(WPL * YS, 2);
        model_run();
        run_stream(100, 100);
        compare_out("eol");
        check_status("eol");
        @(posedge aclk);
        #1;
        err_clr = 1'b1;
        @(posedge aclk);
        #1;
        err_clr  = 1'b0;
        exp_eeol = 1'b0;
        exp_esof = 1'b0;
        check_status("eol_clr");

        push_frame_words(3 * WPL + 10, -1);
        push_frame_words(WPL * YS, -1);
        model_run();
        run_stream(80, 70);
        compare_out("sof");
        check_status("sof");

        @(posedge aclk);
        #1;
        pix_ready        = 1'b1;
        in_stream_tvalid = 1'b1;
        in_stream_tuser  = 1'b1;
        in_stream_tlast  = 1'b0;
        in_stream_tdata  = $urandom;
        @(posedge aclk);
        #1;
        in_stream_tuser = 1'b0;
        in_stream_tdata = $urandom;
        @(posedge aclk);
        #1;
        in_stream_tvalid = 1'b0;
        #2;
        aresetn = 1'b0;
        #1;
        check_reset_outs("midline");
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        model_reset();
        #1;
        chk("midline_tready_before_edge", 32'(in_stream_tready), 32'd0);
        push_junk(4);
        push_frame_words(WPL * YS, -1);
        model_run();
        run_stream(90, 60);
        compare_out("recover");
        check_status("recover");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
